// File: rtl/multiword_add_seq_pkg.sv
// Shared types and constants for the multi-limb add/subtract sequencer.
//   LIMB_W    : width of one limb (the adder width)
//   WORDS_MAX : largest supported limb count per operand
//   limb_t    : one limb
//   idx_t     : beat index, wide enough for WORDS_MAX beats
//   beat_t    : one registered result beat
package multiword_add_seq_pkg;
  localparam int LIMB_W    = 8;
  localparam int WORDS_MAX = 16;

  typedef logic [LIMB_W-1:0]            limb_t;
  typedef logic [$clog2(WORDS_MAX)-1:0] idx_t;

  typedef struct packed {
    limb_t sum;
    logic  last;
    logic  cout;
    logic  ovf;
  } beat_t;
endpackage

// File: rtl/multiword_add_seq_if.sv
// Limb stream interface for multiword_add_seq.
//   in_*  : operand limb pair (valid/ready), in_sub = mode on first limb
//   out_* : result limb (valid/ready) with last/cout/ovf flags
// master = producer/consumer side (bench), slave = sequencer side.
interface multiword_add_seq_if;
  import multiword_add_seq_pkg::*;

  logic  in_valid;
  logic  in_ready;
  limb_t in_a;
  limb_t in_b;
  logic  in_sub;
  logic  out_valid;
  logic  out_ready;
  limb_t out_sum;
  logic  out_last;
  logic  out_cout;
  logic  out_ovf;

  modport master (
    output in_valid, in_a, in_b, in_sub, out_ready,
    input  in_ready, out_valid, out_sum, out_last, out_cout, out_ovf
  );

  modport slave (
    input  in_valid, in_a, in_b, in_sub, out_ready,
    output in_ready, out_valid, out_sum, out_last, out_cout, out_ovf
  );
endinterface

// File: rtl/multiword_add_seq_adder.sv
// adder_carry8: purely combinational limb adder.
//   a, b : limb operands
//   cin  : carry in
//   sum  : limb result
//   cout : carry out
module adder_carry8
  import multiword_add_seq_pkg::*;
(
  input  limb_t a,
  input  limb_t b,
  input  logic  cin,
  output limb_t sum,
  output logic  cout
);
  assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{LIMB_W{1'b0}}, cin};
endmodule

// File: rtl/multiword_add_seq.sv
// multiword_add_seq: streams WORDS-limb operands through one limb adder,
// LS limb first, carrying between limbs in a register. Add or subtract,
// chosen on the first limb. Results are registered behind valid/ready.
//   clk, rst : clock, async active-high reset
//   flush    : synchronous abort of the current operation
//   bus      : limb stream interface (slave side)
module multiword_add_seq
  import multiword_add_seq_pkg::*;
#(
  parameter int WORDS = 4
) (
  input logic               clk,
  input logic               rst,
  input logic               flush,
  multiword_add_seq_if.slave bus
);
  localparam idx_t LAST_IDX = idx_t'(WORDS - 1);

  idx_t  idx;
  logic  cq;
  logic  sub_q;
  logic  out_valid;
  beat_t beat_q;

  logic  first, is_last, mode, cin, cout, ovf, accept;
  limb_t b_eff, sum;

  // The first beat takes mode and carry-in straight from in_sub so a
  // subtract becomes A + ~B + 1 without an extra setup cycle.
  always_comb begin
    first   = (idx == '0);
    is_last = (idx == LAST_IDX);
    mode    = first ? bus.in_sub : sub_q;
    cin     = first ? bus.in_sub : cq;
    b_eff   = mode ? ~bus.in_b : bus.in_b;
  end

  adder_carry8 u_add (
    .a    (bus.in_a),
    .b    (b_eff),
    .cin  (cin),
    .sum  (sum),
    .cout (cout)
  );

  // Signed overflow: operand signs agree but result sign differs.
  assign ovf = (bus.in_a[LIMB_W-1] ~^ b_eff[LIMB_W-1]) & (sum[LIMB_W-1] ^ bus.in_a[LIMB_W-1]);

  assign bus.in_ready = !flush & (!out_valid | bus.out_ready);
  assign accept       = bus.in_valid & bus.in_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx       <= '0;
      cq        <= 1'b0;
      sub_q     <= 1'b0;
      out_valid <= 1'b0;
      beat_q    <= '0;
    end else if (flush) begin
      idx       <= '0;
      cq        <= 1'b0;
      sub_q     <= 1'b0;
      out_valid <= 1'b0;
    end else if (accept) begin
      beat_q.sum  <= sum;
      beat_q.last <= is_last;
      beat_q.cout <= is_last & cout;
      beat_q.ovf  <= is_last & ovf;
      out_valid   <= 1'b1;
      if (is_last) begin
        idx   <= '0;
        cq    <= 1'b0;
        sub_q <= 1'b0;
      end else begin
        idx   <= idx + idx_t'(1);
        cq    <= cout;
        sub_q <= mode;
      end
    end else if (bus.out_ready) begin
      out_valid <= 1'b0;
    end
  end

  assign bus.out_valid = out_valid;
  assign bus.out_sum   = beat_q.sum;
  assign bus.out_last  = beat_q.last;
  assign bus.out_cout  = beat_q.cout;
  assign bus.out_ovf   = beat_q.ovf;
endmodule

// File: tb/tb_multiword_add_seq.sv
// Self-checking bench for multiword_add_seq (WORDS=4): table vectors,
// random ops against a 32-bit arithmetic model, backpressure, flush, reset.
module tb_multiword_add_seq;
  localparam int WORDS = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic flush = 1'b0;

  multiword_add_seq_if bus ();

  multiword_add_seq #(.WORDS(WORDS)) dut (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] sum;
    logic       last;
    logic       cout;
    logic       ovf;
  } beat_t;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        s;
    logic [31:0] r;
    logic        cout;
    logic        ovf;
  } vec_t;

  beat_t exp_q[$];
  int vectors = 0;
  int miscompares = 0;
  int hold_lo = 0;
  bit rand_rdy = 0;

  function automatic void push_beats(input logic [31:0] r, input logic c, input logic o);
    beat_t bt;
    for (int i = 0; i < WORDS; i++) begin
      bt.sum  = r[8*i +: 8];
      bt.last = (i == WORDS - 1);
      bt.cout = (i == WORDS - 1) ? c : 1'b0;
      bt.ovf  = (i == WORDS - 1) ? o : 1'b0;
      exp_q.push_back(bt);
    end
  endfunction

  // Whole-word reference: A + B or A - B as A + ~B + 1 on 33 bits.
  function automatic void push_model(input logic [31:0] a, input logic [31:0] b, input logic s);
    logic [32:0] r;
    logic [31:0] be;
    logic        o;
    be = s ? ~b : b;
    r  = {1'b0, a} + {1'b0, be} + {32'd0, s};
    o  = (a[31] == be[31]) && (r[31] != a[31]);
    push_beats(r[31:0], r[32], o);
  endfunction

  // Drive n limbs of one op; call at posedge+1, returns at posedge+1.
  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic s, input int n);
    bit ok;
    int guard;
    for (int i = 0; i < n; i++) begin
      bus.in_valid = 1'b1;
      bus.in_a     = a[8*i +: 8];
      bus.in_b     = b[8*i +: 8];
      bus.in_sub   = (i == 0) ? s : 1'($urandom);
      guard = 0;
      ok = 0;
      while (!ok) begin
        @(negedge clk);
        ok = bus.in_ready;
        @(posedge clk);
        #1;
        guard++;
        if (guard > 200) begin
          vectors++;
          miscompares++;
          $display("FAIL send_timeout limb %0d never accepted", i);
          ok = 1;
        end
      end
    end
    bus.in_valid = 1'b0;
  endtask

  // out_ready driver
  initial begin
    bus.out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (hold_lo > 0) begin
        bus.out_ready = 1'b0;
        hold_lo--;
      end else begin
        bus.out_ready = rand_rdy ? ($urandom_range(0, 3) != 0) : 1'b1;
      end
    end
  end

  // Output monitor: scoreboard, hold stability, in_ready rule.
  bit    held = 0;
  beat_t held_b;
  always @(negedge clk) begin
    beat_t got, ex;
    got = {bus.out_sum, bus.out_last, bus.out_cout, bus.out_ovf};
    if (rst || flush) begin
      held = 0;
    end else begin
      vectors++;
      if (bus.in_ready !== (!bus.out_valid || bus.out_ready)) begin
        miscompares++;
        $display("FAIL in_ready got %b want %b", bus.in_ready, (!bus.out_valid || bus.out_ready));
      end
      if (held) begin
        vectors++;
        if (!bus.out_valid || got !== held_b) begin
          miscompares++;
          $display("FAIL hold_stable got v=%b %h want v=1 %h", bus.out_valid, got, held_b);
        end
      end
      if (bus.out_valid && bus.out_ready) begin
        vectors++;
        held = 0;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL unexpected_beat got %h want none", got);
        end else begin
          ex = exp_q.pop_front();
          if (got !== ex) begin
            miscompares++;
            $display("FAIL beat got sum=%h last=%b cout=%b ovf=%b want sum=%h last=%b cout=%b ovf=%b",
                     got.sum, got.last, got.cout, got.ovf, ex.sum, ex.last, ex.cout, ex.ovf);
          end
        end
      end else if (bus.out_valid) begin
        held = 1;
        held_b = got;
      end else begin
        held = 0;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s got %h want %h", name, got, want);
    end
  endtask

  task automatic check_reset_outs(input string name);
    check({name, "_valid"}, 32'(bus.out_valid), 32'd0);
    check({name, "_sum"},   32'(bus.out_sum),   32'd0);
    check({name, "_flags"}, {29'd0, bus.out_last, bus.out_cout, bus.out_ovf}, 32'd0);
  endtask

  task automatic drain(input string name);
    int guard = 0;
    while (exp_q.size() != 0 && guard < 300) begin
      @(posedge clk);
      #1;
      guard++;
    end
    check(name, 32'(exp_q.size()), 32'd0);
  endtask

  vec_t tbl[6];

  initial begin
    bus.in_valid = 1'b0;
    bus.in_a = '0;
    bus.in_b = '0;
    bus.in_sub = 1'b0;

    tbl[0] = '{32'h000000FF, 32'h00000001, 1'b0, 32'h00000100, 1'b0, 1'b0};
    tbl[1] = '{32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h00000000, 1'b1, 1'b0};
    tbl[2] = '{32'h00000005, 32'h00000007, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0};
    tbl[3] = '{32'h7FFFFFFF, 32'h00000001, 1'b0, 32'h80000000, 1'b0, 1'b1};
    tbl[4] = '{32'h80000000, 32'h00000001, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1};
    tbl[5] = '{32'h00000007, 32'h00000005, 1'b1, 32'h00000002, 1'b1, 1'b0};

    #1;
    check_reset_outs("reset");
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Table vectors, back to back (mode must not leak between ops).
    for (int i = 0; i < 6; i++) begin
      push_beats(tbl[i].r, tbl[i].cout, tbl[i].ovf);
      send(tbl[i].a, tbl[i].b, tbl[i].s, WORDS);
    end
    drain("table_drain");

    // Backpressure: out_ready low 3 cycles after the first output.
    push_beats(32'h00000100, 1'b0, 1'b0);
    fork
      send(32'h000000FF, 32'h00000001, 1'b0, WORDS);
      begin
        int g = 0;
        @(negedge clk);
        while (!bus.out_valid && g < 50) begin
          @(negedge clk);
          g++;
        end
        hold_lo = 3;
      end
    join
    drain("stall_drain");

    // Flush after 2 limbs, with in_valid raised during the flush cycle.
    push_model(32'hFFFFFFFF, 32'h00000001, 1'b0);
    send(32'hFFFFFFFF, 32'h00000001, 1'b0, 2);
    flush = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_a = 8'hFF;
    bus.in_b = 8'hFF;
    @(negedge clk);
    check("flush_in_ready", 32'(bus.in_ready), 32'd0);
    @(posedge clk);
    #1;
    flush = 1'b0;
    bus.in_valid = 1'b0;
    check("flush_out_valid", 32'(bus.out_valid), 32'd0);
    exp_q.delete();
    push_beats(32'h00000002, 1'b0, 1'b0);
    send(32'h00000001, 32'h00000001, 1'b0, WORDS);
    drain("flush_drain");

    // Async reset mid-operation.
    push_model(32'hFFFFFFFF, 32'h00000001, 1'b0);
    send(32'hFFFFFFFF, 32'h00000001, 1'b0, 2);
    #2;
    rst = 1'b1;
    #1;
    check_reset_outs("midrst");
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
    push_beats(32'h00000002, 1'b0, 1'b0);
    send(32'h00000001, 32'h00000001, 1'b0, WORDS);
    drain("rst_drain");

    // Random ops with random downstream stalls.
    rand_rdy = 1;
    for (int i = 0; i < 40; i++) begin
      logic [31:0] a, b;
      logic s;
      a = $urandom;
      b = $urandom;
      s = 1'($urandom);
      if (i % 8 == 0) a = 32'h7FFFFFFF;
      push_model(a, b, s);
      send(a, b, s, WORDS);
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk);
        #1;
      end
    end
    drain("rand_drain");
    rand_rdy = 0;
    repeat (3) @(posedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/multiword_add_seq.md
# multiword_add_seq

Sequencer that streams multi-limb operands through an 8-bit carry-propagate adder, one limb per cycle, least-significant limb first. It carries the limb-to-limb carry in a register and supports add and subtract modes. Results are registered behind a valid/ready handshake. It sits directly around the 8-bit adder: it drives the adder's operands and carry-in, and consumes the adder's sum and carry-out.

## Interface
- WORDS, 4, limbs per operand (legal 1..16); operand width = 8*WORDS
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- flush  input  1  synchronous abort of the current operation
- in_valid  input  1  limb pair present
- in_ready  output  1  limb pair accepted when in_valid & in_ready
- in_a  input  8  operand A limb
- in_b  input  8  operand B limb
- in_sub  input  1  mode, sampled on first limb only: 0 = A+B, 1 = A−B
- out_valid  output  1  result limb present
- out_ready  input  1  downstream accepts result limb
- out_sum  output  8  result limb
- out_last  output  1  high on the final limb (index WORDS−1)
- out_cout  output  1  final carry-out; valid only with out_last, else 0
- out_ovf  output  1  signed overflow of full-width result; valid only with out_last, else 0

## Operation
- State: beat index idx (0..WORDS−1), carry register cq, mode register sub_q, output register.
- Effective B is in_b on add; ~in_b on subtract.
- Carry-in cin is in_sub when idx=0; otherwise cq.
- Mode source: idx=0 uses in_sub directly, and sub_q is loaded from it; other beats use sub_q.
- On accept:
  - adder computes {cout, sum} = in_a + b_eff + cin.
  - output register loads sum, last = (idx==WORDS−1), cout and ovf (last only).
  - cq loads cout.
  - idx increments, wrapping to 0 after WORDS−1; on the wrap, cq and sub_q clear.
- Subtract: out_cout=1 means no borrow (A ≥ B unsigned).
- Overflow on the last limb: ovf = (in_a[7] ~^ b_eff[7]) & (sum[7] ^ in_a[7]).
- Output register holds stable while out_valid & !out_ready.
- in_sub on non-first beats is ignored.
- WORDS=1: every beat is first and last.
- Flush: idx←0, cq←0, sub_q←0, out_valid←0. in_ready is low that cycle, so no limb is accepted; flush wins over a simultaneous in_valid. A held output beat is discarded.
- Reset (any time, including mid-operation): idx=0, cq=0, sub_q=0, out_valid=0, out_sum=0x00, out_last=0, out_cout=0, out_ovf=0. The partial operation is discarded.

## Timing
- Latency: 1 cycle, limb accepted at edge N appears on out_* after edge N.
- Throughput: 1 limb/cycle when out_ready is held high.
- in_ready = !flush & (!out_valid | out_ready), combinational from out_ready and flush.
- Upstream may not change in_a, in_b or in_sub while in_valid & !in_ready.
- Output beat completes on out_valid & out_ready. Simultaneous completion and new accept in the same cycle is legal: the output reloads with no bubble.
- Carry path is registered per limb; no combinational path from in_a/in_b to out_*.

## Structure
- Shared package: LIMB_W=8 constant, WORDS_MAX=16 constant, limb typedef, idx typedef sized for WORDS_MAX.
- One sub-module: adder_carry8, a purely combinational 8-bit add with inputs a, b, cin and outputs sum, cout. The sequencer holds all state.

## Test plan
- WORDS=4, add 0x000000FF+0x00000001 → out_sum 00,01,00,00; out_last on 4th beat only; cout=0, ovf=0.
- Add 0xFFFFFFFF+0x00000001 → 00,00,00,00; cout=1, ovf=0.
- Subtract 0x00000005−0x00000007 → FE,FF,FF,FF; cout=0 (borrow), ovf=0. A second back-to-back op 0x7FFFFFFF+0x00000001 (add) → 00,00,00,80; ovf=1, cout=0; mode must not leak between ops.
- Backpressure: out_ready low for 3 cycles after first output → in_ready low for those cycles, out_sum stable, no limb lost or duplicated; final sequence is identical to the unstalled run.
- Flush after 2 limbs of 0xFFFFFFFF+0x00000001, then 0x00000001+0x00000001 → first output 02 (cq cleared); out_last on the 4th limb of the new op; flush asserted together with in_valid accepts nothing.
- rst asserted mid-operation (asynchronously, between edges) → all outputs go to reset values immediately; the next op starts at idx 0 with cin 0.
